// File: rtl/pixel_sink.sv
// Receiving end of the DPU video output. It captures {X,Y,Colour} words on each
// outEnable level change, buffers them, and writes them to the framebuffer or runs a full-frame clear.
module pixel_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = 255,
  parameter int Y_MAX      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] Kbus,
  input  logic        outEnable,
  input  logic        clearReq,
  input  logic [7:0]  clearColour,
  input  logic        fbReady,
  output logic [15:0] fbAddr,
  output logic [7:0]  fbData,
  output logic        fbWrite,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  clipCount,
  output logic [15:0] pixelCount
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [8:0] X_LIM   = 9'(X_MAX);
  localparam logic [8:0] Y_LIM   = 9'(Y_MAX);
  localparam logic [7:0] X_END   = 8'(X_MAX);
  localparam logic [7:0] Y_END   = 8'(Y_MAX);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t        state;
  logic          prev_oe;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          clear_pend;
  logic [7:0]    clear_colour;

  logic          pix_event, clip, empty, full, pop, push;
  logic [23:0]   head;

  assign pix_event = (outEnable != prev_oe);
  assign clip      = ({1'b0, Kbus[23:16]} > X_LIM) || ({1'b0, Kbus[15:8]} > Y_LIM);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  // A pending clear outranks draining the FIFO.
  assign pop       = (state == IDLE) && !clear_pend && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = pix_event && !clip && (!full || pop);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty || clear_pend;

  // NOTE: the pixel storage carries no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Kbus;
  end

  // NOTE: every register here uses <= so all reads in this block see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prev_oe      <= outEnable;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      clear_pend   <= 1'b0;
      clear_colour <= '0;
      fbAddr       <= '0;
      fbData       <= '0;
      fbWrite      <= 1'b0;
      overflow     <= 1'b0;
      clipCount    <= '0;
      pixelCount   <= '0;
    end else begin
      prev_oe <= outEnable;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pix_event && !clip && full && !pop) overflow <= 1'b1;
      if (pix_event && clip && clipCount != 8'hFF) clipCount <= clipCount + 1'b1;

      // The flag stays high through CLEAR, so a request then is ignored.
      if (clearReq && !clear_pend) begin
        clear_pend   <= 1'b1;
        clear_colour <= clearColour;
      end

      unique case (state)
        IDLE: begin
          if (clear_pend) begin
            state   <= CLEAR;
            fbAddr  <= '0;
            fbData  <= clear_colour;
            fbWrite <= 1'b1;
          end else if (!empty) begin
            state   <= WRITE;
            fbAddr  <= {head[15:8], head[23:16]};
            fbData  <= head[7:0];
            fbWrite <= 1'b1;
          end
        end
        WRITE: begin
          if (fbReady) begin
            state      <= IDLE;
            fbWrite    <= 1'b0;
            pixelCount <= pixelCount + 1'b1;
          end
        end
        CLEAR: begin
          if (fbReady) begin
            if (fbAddr[7:0] == X_END) begin
              fbAddr[7:0] <= '0;
              if (fbAddr[15:8] == Y_END) begin
                state      <= IDLE;
                fbWrite    <= 1'b0;
                clear_pend <= 1'b0;
              end else begin
                fbAddr[15:8] <= fbAddr[15:8] + 1'b1;
              end
            end else begin
              fbAddr[7:0] <= fbAddr[7:0] + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink. Instance a has X_MAX=255 and Y_MAX=99 and covers pixel, backpressure and clip.
// Instance b has X_MAX=3 and Y_MAX=1 and covers the clear cases.
module tb_pixel_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] Kbus;
  logic        outEnable;
  logic        clearReq;
  logic [7:0]  clearColour;
  logic        fbReady;

  logic [15:0] a_fbAddr, b_fbAddr, a_pixelCount, b_pixelCount;
  logic [7:0]  a_fbData, b_fbData, a_clipCount, b_clipCount;
  logic        a_fbWrite, b_fbWrite, a_busy, b_busy, a_overflow, b_overflow;

  int checks = 0;
  int errors = 0;
  logic [23:0] a_wr[$];
  logic [23:0] b_wr[$];

  always #5 clk = ~clk;

  pixel_sink #(.FIFO_DEPTH(4), .X_MAX(255), .Y_MAX(99)) u_a (
    .clk(clk), .reset(reset), .Kbus(Kbus), .outEnable(outEnable), .clearReq(clearReq),
    .clearColour(clearColour), .fbReady(fbReady), .fbAddr(a_fbAddr), .fbData(a_fbData),
    .fbWrite(a_fbWrite), .busy(a_busy), .overflow(a_overflow), .clipCount(a_clipCount),
    .pixelCount(a_pixelCount));

  pixel_sink #(.FIFO_DEPTH(4), .X_MAX(3), .Y_MAX(1)) u_b (
    .clk(clk), .reset(reset), .Kbus(Kbus), .outEnable(outEnable), .clearReq(clearReq),
    .clearColour(clearColour), .fbReady(fbReady), .fbAddr(b_fbAddr), .fbData(b_fbData),
    .fbWrite(b_fbWrite), .busy(b_busy), .overflow(b_overflow), .clipCount(b_clipCount),
    .pixelCount(b_pixelCount));

  // Completed writes are logged mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!reset && fbReady && a_fbWrite) a_wr.push_back({a_fbAddr, a_fbData});
    if (!reset && fbReady && b_fbWrite) b_wr.push_back({b_fbAddr, b_fbData});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    Kbus      = {x, y, c};
    outEnable = ~outEnable;
    tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    clearReq = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    a_wr.delete();
    b_wr.delete();
  endtask

  task automatic test_reset();
    outEnable = 1'b1;
    Kbus      = 24'h010203;
    do_reset();
    checks++; if (a_fbWrite !== 1'b0) begin errors++; $display("FAIL reset_fbWrite got %b want 0", a_fbWrite); end
    checks++; if (a_fbAddr !== 16'h0) begin errors++; $display("FAIL reset_fbAddr got %h want 0000", a_fbAddr); end
    checks++; if (a_fbData !== 8'h0) begin errors++; $display("FAIL reset_fbData got %h want 00", a_fbData); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", a_overflow); end
    checks++; if (a_clipCount !== 8'h0) begin errors++; $display("FAIL reset_clipCount got %0d want 0", a_clipCount); end
    checks++; if (a_pixelCount !== 16'h0) begin errors++; $display("FAIL reset_pixelCount got %0d want 0", a_pixelCount); end
    repeat (4) tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_no_event busy got %b want 0", a_busy); end
    checks++; if (a_wr.size() !== 0) begin errors++; $display("FAIL reset_no_event writes got %0d want 0", a_wr.size()); end
  endtask

  task automatic test_single();
    do_reset();
    fbReady = 1'b1;
    pixel(8'h0A, 8'h14, 8'h07);
    checks++; if (a_fbWrite !== 1'b0) begin errors++; $display("FAIL single_n1 fbWrite got %b want 0", a_fbWrite); end
    tick();
    checks++; if (a_fbWrite !== 1'b1) begin errors++; $display("FAIL single_n2 fbWrite got %b want 1", a_fbWrite); end
    checks++; if (a_fbAddr !== 16'h140A) begin errors++; $display("FAIL single_addr got %h want 140a", a_fbAddr); end
    checks++; if (a_fbData !== 8'h07) begin errors++; $display("FAIL single_data got %h want 07", a_fbData); end
    tick();
    checks++; if (a_fbWrite !== 1'b0) begin errors++; $display("FAIL single_n3 fbWrite got %b want 0", a_fbWrite); end
    checks++; if (a_pixelCount !== 16'd1) begin errors++; $display("FAIL single_pixelCount got %0d want 1", a_pixelCount); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", a_busy); end
    checks++; if (a_wr.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", a_wr.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fbReady = 1'b0;
    for (int x = 1; x <= 6; x++) pixel(8'(x), 8'h00, 8'(x));
    checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", a_overflow); end
    repeat (3) tick();
    checks++; if (a_fbWrite !== 1'b1) begin errors++; $display("FAIL bp_stall fbWrite got %b want 1", a_fbWrite); end
    checks++; if (a_fbAddr !== 16'h0001) begin errors++; $display("FAIL bp_stall addr got %h want 0001", a_fbAddr); end
    fbReady = 1'b1;
    for (int i = 0; i < 60 && a_busy; i++) tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_drain_timeout busy got %b want 0", a_busy); end
    checks++; if (a_wr.size() !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", a_wr.size()); end
    for (int i = 0; i < 5 && i < a_wr.size(); i++) begin
      checks++;
      if (a_wr[i] !== {16'(i + 1), 8'(i + 1)}) begin
        errors++; $display("FAIL bp_order[%0d] got %h want %h", i, a_wr[i], {16'(i + 1), 8'(i + 1)});
      end
    end
    checks++; if (a_pixelCount !== 16'd5) begin errors++; $display("FAIL bp_pixelCount got %0d want 5", a_pixelCount); end
  endtask

  task automatic test_clip();
    do_reset();
    fbReady = 1'b1;
    pixel(8'h05, 8'd100, 8'h33);
    repeat (4) tick();
    checks++; if (a_wr.size() !== 0) begin errors++; $display("FAIL clip_dropped writes got %0d want 0", a_wr.size()); end
    checks++; if (a_clipCount !== 8'd1) begin errors++; $display("FAIL clip_count got %0d want 1", a_clipCount); end
    pixel(8'h05, 8'd99, 8'h44);
    repeat (4) tick();
    checks++; if (a_wr.size() !== 1) begin errors++; $display("FAIL clip_edge writes got %0d want 1", a_wr.size()); end
    else if (a_wr[0] !== 24'h630544) begin errors++; $display("FAIL clip_edge word got %h want 630544", a_wr[0]); end
    checks++; if (a_clipCount !== 8'd1) begin errors++; $display("FAIL clip_edge count got %0d want 1", a_clipCount); end
    for (int i = 0; i < 300; i++) pixel(8'h00, 8'hC8, 8'h00);
    checks++; if (a_clipCount !== 8'd255) begin errors++; $display("FAIL clip_saturate got %0d want 255", a_clipCount); end
  endtask

  task automatic test_clear();
    do_reset();
    fbReady     = 1'b1;
    clearColour = 8'h55;
    clearReq    = 1'b1;
    tick();
    clearReq    = 1'b0;
    clearColour = 8'h00;
    for (int i = 0; i < 60 && b_busy; i++) tick();
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL clear_timeout busy got %b want 0", b_busy); end
    checks++; if (b_wr.size() !== 8) begin errors++; $display("FAIL clear_count got %0d want 8", b_wr.size()); end
    for (int i = 0; i < 8 && i < b_wr.size(); i++) begin
      checks++;
      if (b_wr[i] !== {8'(i / 4), 8'(i % 4), 8'h55}) begin
        errors++; $display("FAIL clear_word[%0d] got %h want %h", i, b_wr[i], {8'(i / 4), 8'(i % 4), 8'h55});
      end
    end
    checks++; if (b_pixelCount !== 16'd0) begin errors++; $display("FAIL clear_pixelCount got %0d want 0", b_pixelCount); end
  endtask

  task automatic test_clear_during_write();
    logic [23:0] exp[$];
    do_reset();
    fbReady = 1'b0;
    pixel(8'h02, 8'h01, 8'h9A);
    tick();
    clearColour = 8'h3C;
    clearReq    = 1'b1;
    tick();
    clearReq    = 1'b0;
    clearColour = 8'h00;
    tick();
    checks++; if (b_fbAddr !== 16'h0102 || b_fbWrite !== 1'b1) begin
      errors++; $display("FAIL cdw_stall got addr %h wr %b want 0102 1", b_fbAddr, b_fbWrite);
    end
    fbReady = 1'b1;
    for (int i = 0; i < 40 && b_wr.size() < 3; i++) tick();
    checks++; if (b_wr.size() < 3) begin errors++; $display("FAIL cdw_clear_start_timeout got %0d writes want 3", b_wr.size()); end
    clearReq    = 1'b1;
    clearColour = 8'hEE;
    pixel(8'h01, 8'h00, 8'h77);
    clearReq    = 1'b0;
    for (int i = 0; i < 60 && b_busy; i++) tick();
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL cdw_timeout busy got %b want 0", b_busy); end
    exp.push_back(24'h01029A);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) exp.push_back({8'(y), 8'(x), 8'h3C});
    exp.push_back(24'h000177);
    checks++; if (b_wr.size() !== exp.size()) begin errors++; $display("FAIL cdw_count got %0d want %0d", b_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < b_wr.size(); i++) begin
      checks++;
      if (b_wr[i] !== exp[i]) begin errors++; $display("FAIL cdw_word[%0d] got %h want %h", i, b_wr[i], exp[i]); end
    end
    checks++; if (b_pixelCount !== 16'd2) begin errors++; $display("FAIL cdw_pixelCount got %0d want 2", b_pixelCount); end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    fbReady     = 1'b1;
    clearColour = 8'h11;
    clearReq    = 1'b1;
    tick();
    clearReq    = 1'b0;
    pixel(8'h00, 8'h00, 8'h01);
    pixel(8'h01, 8'h00, 8'h02);
    checks++; if (b_fbWrite !== 1'b1) begin errors++; $display("FAIL rmc_in_clear fbWrite got %b want 1", b_fbWrite); end
    reset = 1'b1;
    tick();
    checks++; if (b_fbWrite !== 1'b0) begin errors++; $display("FAIL rmc_fbWrite got %b want 0", b_fbWrite); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got %b want 0", b_busy); end
    checks++; if (b_pixelCount !== 16'd0 || b_clipCount !== 8'd0) begin
      errors++; $display("FAIL rmc_counters got %0d %0d want 0 0", b_pixelCount, b_clipCount);
    end
    reset = 1'b0;
    b_wr.delete();
    repeat (20) tick();
    checks++; if (b_wr.size() !== 0) begin errors++; $display("FAIL rmc_no_writes got %0d want 0", b_wr.size()); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rmc_idle busy got %b want 0", b_busy); end
  endtask

  initial begin
    reset       = 1'b1;
    Kbus        = '0;
    outEnable   = 1'b0;
    clearReq    = 1'b0;
    clearColour = '0;
    fbReady     = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_clip();
    test_clear();
    test_clear_during_write();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_sink.md
Name: pixel_sink

Overview:
- Receiving end of the DPU video output.
- Captures each {X, Y, Colour} pixel word presented on the DPU's 24-bit Kbus whenever the DPU signals video out via outEnable.
- Buffers captured pixels in a small FIFO and drains them into the framebuffer memory port with a write/ready handshake.
- Also supports a whole-frame clear to a given colour.

Parameters:
FIFO_DEPTH, 4, number of pixel entries buffered (power of two, >= 2)
X_MAX, 255, largest accepted X coordinate; larger X is clipped
Y_MAX, 255, largest accepted Y coordinate; larger Y is clipped

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
Kbus  input  24  pixel word: [23:16] X, [15:8] Y, [7:0] Colour
outEnable  input  1  video-out strobe from DPU; any level change = one pixel event
clearReq  input  1  one-cycle pulse, request frame clear
clearColour  input  8  colour used for clear, sampled on the clearReq cycle
fbReady  input  1  framebuffer accepts write when high with fbWrite
fbAddr  output  16  framebuffer address, {Y, X}
fbData  output  8  framebuffer write data (colour)
fbWrite  output  1  write request; held until fbReady
busy  output  1  high when FIFO non-empty, a write is outstanding, or a clear is active or pending
overflow  output  1  sticky: a pixel event arrived with the FIFO full
clipCount  output  8  count of clipped pixels, saturates at 255
pixelCount  output  16  count of completed pixel writes (excluding clear), wraps

Behaviour:
- Reset (synchronous, active-high) values:
  - All outputs: fbWrite=0, fbAddr=0, fbData=0, busy=0, overflow=0, clipCount=0, pixelCount=0.
  - FIFO empty, clear-pending flag cleared, FSM in IDLE.
  - The registered previous outEnable is loaded with the current outEnable, so no spurious event occurs after reset.
  - Reset mid-write or mid-clear aborts immediately and discards FIFO contents.
- Event detect: pixel event in cycle N when outEnable != registered previous value. Kbus is sampled in cycle N.
- Clip check at capture:
  - If X > X_MAX or Y > Y_MAX, the pixel is dropped and clipCount increments (saturating). It is not pushed.
  - Otherwise it is pushed, if the FIFO is not full.
- Full FIFO: a push with the FIFO full drops the pixel and sets overflow. FIFO contents are unchanged.
- Same-cycle push and pop with the FIFO full: the pop frees a slot and the push is accepted; no overflow.
- FSM states IDLE, WRITE, CLEAR:
  - IDLE, clear pending: enter CLEAR with X=0, Y=0. Clear has priority over FIFO pops.
  - IDLE, FIFO non-empty: pop head, load fbAddr={Y,X} and fbData=Colour, assert fbWrite next cycle, enter WRITE. Minimum latency: event in cycle N, fbWrite high in cycle N+2.
  - WRITE: hold fbAddr, fbData and fbWrite stable until a cycle with fbReady=1. In that cycle the write completes and pixelCount increments. The next cycle returns to IDLE with fbWrite=0.
  - CLEAR: fbWrite=1, fbData=latched clearColour, fbAddr={Y,X}.
    - On each fbReady, X increments. At X_MAX, X wraps to 0 and Y increments.
    - Completing the write at (X_MAX, Y_MAX) returns to IDLE and clears the pending flag.
    - Total clear writes: (X_MAX+1)*(Y_MAX+1).
- clearReq timing:
  - During WRITE: latched as pending; CLEAR starts after the current write completes.
  - During CLEAR: ignored; clearColour is not re-sampled.
- Pixel events during CLEAR continue to be captured into the FIFO (subject to overflow). They are written after the clear, in arrival order.
- busy is combinational from state, FIFO-empty and pending flags.
- Counters:
  - pixelCount wraps 65535 -> 0.
  - clipCount holds at 255.

Test Plan:
- Single pixel: Kbus=0x0A_14_07, toggle outEnable, fbReady=1 -> one write, fbAddr=0x140A, fbData=0x07, fbWrite high exactly 1 cycle, pixelCount=1, busy low afterward.
- Backpressure and overflow: fbReady=0, 6 events with X=1..6 (FIFO_DEPTH=4) -> first pixel stalls in WRITE; X=2..5 fill the FIFO; 6th dropped, overflow=1. Then raise fbReady -> addresses X=1..5 written in order, pixelCount=5.
- Clip: X_MAX=255, Y_MAX=99, event with Y=100 -> no fbWrite, clipCount=1. Event with Y=99 -> written normally.
- Clear: X_MAX=3, Y_MAX=1, clearReq with clearColour=0x55, fbReady=1 -> 8 writes, addresses 0x0000..0x0003 then 0x0100..0x0103, data 0x55, pixelCount stays 0.
- Clear during write, pixel during clear: clearReq while WRITE is stalled, then a pixel event mid-clear -> stalled pixel completes first, then the full clear, then the buffered pixel.
- Reset mid-clear with FIFO holding 2 entries -> next cycle fbWrite=0, busy=0, counters 0, and no writes follow without new events.
